uart_frame_packer: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_frame_packer.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_packer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame packer.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
// Contents: FSM state enum, frame byte-index enum, CRC-8 polynomial and a
// one-byte CRC-8 step (MSB-first, no reflection).
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE
  } state_e;

  typedef enum logic [1:0] {
    IDX_SYNC,
    IDX_SEQ,
    IDX_DATA,
    IDX_CHECK
  } idx_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Fold one byte into a running CRC-8, processing bit 7 first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational head read.
// Latency: a pushed entry is visible at rdata_o the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i, pop_i/rdata_o,
//        full_o, empty_o, count_o (log2(DEPTH)+1 bits). DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO may accept a push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Packs buffered sample bytes into SYNC,SEQ,DATA[PAYLOAD_LEN],CHECK frames for a UART.
// Latency: first o_Tx_DV 2 cycles after the edge that pushes the PAYLOAD_LEN-th byte.
// Backpressure: waits on i_Tx_Active / i_Tx_Done; samples arriving to a full FIFO are dropped (o_Overflow).
// Ports: i_Clk/i_Rst (sync, active-high); i_Data_DV/i_Data sample input;
//        i_Tx_Active/i_Tx_Done and o_Tx_DV/o_Tx_Byte UART handshake;
//        o_Busy frame in progress, o_Overflow sticky drop flag, o_Seq next frame number.
// Build option: define FRAME_CRC8_EN to make CHECK a CRC-8 (poly 0x07) instead of XOR.
module uart_frame_packer
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 4,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Data_DV,
  input  logic [7:0] i_Data,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Busy,
  output logic       o_Overflow,
  output logic [7:0] o_Seq
);

  localparam int CW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  idx_e          idx_q, idx_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    acc_q, acc_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    seq_q, seq_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [NW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic [7:0]    cur_byte, fold_byte;
  logic          start, issue;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .push_i  (i_Data_DV),
    .wdata_i (i_Data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign start    = (fifo_count >= NW'(PAYLOAD_LEN)) && !i_Tx_Active;
  assign issue    = (state_q == ST_SEND) && !i_Tx_Active;
  // The head byte leaves the FIFO in the same cycle it is registered into o_Tx_Byte.
  assign fifo_pop = issue && (idx_q == IDX_DATA) && !fifo_empty;

  always_comb begin
    cur_byte = SYNC_BYTE;
    unique case (idx_q)
      IDX_SYNC:  cur_byte = SYNC_BYTE;
      IDX_SEQ:   cur_byte = seq_q;
      IDX_DATA:  cur_byte = fifo_head;
      IDX_CHECK: cur_byte = acc_q;
      default:   cur_byte = SYNC_BYTE;
    endcase
  end

`ifdef FRAME_CRC8_EN
  assign fold_byte = crc8_byte(acc_q, cur_byte);
`else
  assign fold_byte = acc_q ^ cur_byte;
`endif

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_SEND;
      ST_SEND:      if (!i_Tx_Active) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_Tx_Done) state_d = (idx_q == IDX_CHECK) ? ST_IDLE : ST_SEND;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    acc_d     = acc_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;
    seq_d     = seq_q;
    ovf_d     = ovf_q | (i_Data_DV && fifo_full && !fifo_pop);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = IDX_SYNC;
          dcnt_d = '0;
          acc_d  = '0;
          busy_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (issue) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = cur_byte;
          if (idx_q == IDX_SEQ || idx_q == IDX_DATA) acc_d = fold_byte;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          unique case (idx_q)
            IDX_SYNC: idx_d = IDX_SEQ;
            IDX_SEQ:  idx_d = IDX_DATA;
            IDX_DATA: begin
              if (dcnt_q == CW'(PAYLOAD_LEN - 1)) idx_d = IDX_CHECK;
              else dcnt_d = dcnt_q + CW'(1);
            end
            IDX_CHECK: begin
              seq_d  = seq_q + 8'd1;
              busy_d = 1'b0;
            end
            default: idx_d = IDX_SYNC;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      idx_q     <= IDX_SYNC;
      dcnt_q    <= '0;
      acc_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      seq_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      acc_q     <= acc_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      seq_q     <= seq_d;
    end
  end

  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = busy_q;
  assign o_Overflow = ovf_q;
  assign o_Seq      = seq_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Self-checking bench for uart_frame_packer with a model UART and a frame-level reference model.
// Latency: n/a.
// Backpressure: the model UART can be held busy to stall the packer and fill its FIFO.
module tb_uart_frame_packer;

  localparam int P = 4;
  localparam int D = 8;

  logic       i_Clk = 1'b0;
  logic       i_Rst, i_Data_DV, i_Tx_Active, i_Tx_Done;
  logic [7:0] i_Data;
  logic       o_Tx_DV, o_Busy, o_Overflow;
  logic [7:0] o_Tx_Byte, o_Seq;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] mseq;
  int         mocc;
  logic       movf;
  int         done_cnt = 0;
  bit         uart_hold = 1'b0;
  int         ucnt;
  int         base;
  int         keep;
  logic [7:0] x;

  always #5 i_Clk = ~i_Clk;

  uart_frame_packer dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Data_DV   (i_Data_DV),
    .i_Data      (i_Data),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Busy      (o_Busy),
    .o_Overflow  (o_Overflow),
    .o_Seq       (o_Seq)
  );

  // Model UART: takes a byte on o_Tx_DV, stays active, pulses Done 10 cycles later.
  initial begin
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    ucnt        = 0;
    forever begin
      @(negedge i_Clk);
      i_Tx_Done = 1'b0;
      if (o_Tx_DV) begin
        got_q.push_back(o_Tx_Byte);
        i_Tx_Active = 1'b1;
        ucnt = 10;
      end else if (i_Tx_Active && !uart_hold) begin
        ucnt--;
        if (ucnt == 0) begin
          i_Tx_Done   = 1'b1;
          i_Tx_Active = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Check byte step: CRC as polynomial long division, or plain XOR.
  function automatic logic [7:0] fold(input logic [7:0] a, input logic [7:0] b);
`ifdef FRAME_CRC8_EN
    logic [15:0] r;
    r = {a ^ b, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
`else
    return a ^ b;
`endif
  endfunction

  task automatic tick();
    @(negedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic emit_frame();
    logic [7:0] c;
    logic [7:0] d;
    exp_q.push_back(8'hA5);
    exp_q.push_back(mseq);
    c = mseq;
    for (int i = 0; i < P; i++) begin
      d = mq.pop_front();
      c = fold(c, d);
      exp_q.push_back(d);
    end
    exp_q.push_back(c);
    mseq = mseq + 8'd1;
  endtask

  // Drive one sample; popping=1 means the bench aimed it at a DATA pop cycle.
  task automatic push(input logic [7:0] b, input bit popping);
    i_Data    = b;
    i_Data_DV = 1'b1;
    tick();
    i_Data_DV = 1'b0;
    if (mocc < D || popping) begin
      mq.push_back(b);
      if (!popping) mocc++;
      while (mq.size() >= P) emit_frame();
    end else begin
      movf = 1'b1;
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < 4000 && got_q.size() < n; i++) tick();
    for (int i = 0; i < 400 && (o_Busy || i_Tx_Active); i++) tick();
    repeat (3) tick();
    chk({tag, "_len"}, got_q.size(), n);
    chk({tag, "_busy"}, {31'd0, o_Busy}, 0);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    mocc = mq.size();
  endtask

  initial begin
    i_Rst = 1'b1; i_Data_DV = 1'b0; i_Data = 8'h00;
    mseq = 8'h00; mocc = 0; movf = 1'b0;
    repeat (3) tick();
    i_Rst = 1'b0;
    tick();
    chk("rst_tx_dv",   {31'd0, o_Tx_DV}, 0);
    chk("rst_tx_byte", {24'd0, o_Tx_Byte}, 0);
    chk("rst_busy",    {31'd0, o_Busy}, 0);
    chk("rst_ovf",     {31'd0, o_Overflow}, 0);
    chk("rst_seq",     {24'd0, o_Seq}, 0);

    // First frame and start latency
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 0);
    chk("lat_edge1", {31'd0, o_Tx_DV}, 0);
    tick();
    chk("lat_edge2_busy", {31'd0, o_Busy}, 1);
    chk("lat_edge2_dv", {31'd0, o_Tx_DV}, 0);
    tick();
    chk("lat_first_dv", {31'd0, o_Tx_DV}, 1);
    chk("lat_first_byte", {24'd0, o_Tx_Byte}, 8'hA5);
    compare_stream("f1");
    chk("f1_seq", {24'd0, o_Seq}, {24'd0, mseq});

    // Two back-to-back frames
    for (int i = 0; i < 8; i++) begin
      x = 8'h10 + 8'(i);
      push(x, 0);
    end
    compare_stream("f23");
    chk("f23_seq", {24'd0, o_Seq}, {24'd0, mseq});

    // Random payloads with random gaps
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        push(8'($urandom), 0);
        repeat ($urandom_range(0, 2)) tick();
      end
      compare_stream($sformatf("rnd%0d", r));
    end
    chk("rnd_seq", {24'd0, o_Seq}, {24'd0, mseq});
    chk("rnd_ovf", {31'd0, o_Overflow}, {31'd0, movf});

    // Overflow: UART stalled, nine samples, ninth must be dropped
    uart_hold = 1'b1;
    for (int i = 0; i < 9; i++) push(8'($urandom), 0);
    tick();
    chk("ovf_set", {31'd0, o_Overflow}, {31'd0, movf});
    chk("ovf_busy", {31'd0, o_Busy}, 1);
    uart_hold = 1'b0;
    compare_stream("ovf");
    chk("ovf_sticky", {31'd0, o_Overflow}, {31'd0, movf});

    // Reset during the DATA[1] wait
    for (int i = 0; i < 4; i++) push(8'($urandom), 0);
    for (int i = 0; i < 2000 && got_q.size() < 4; i++) tick();
    chk("mid_len", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("mid_b%0d", i), got_q[i], exp_q[i]);
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    chk("mid_rst_dv",   {31'd0, o_Tx_DV}, 0);
    chk("mid_rst_byte", {24'd0, o_Tx_Byte}, 0);
    chk("mid_rst_busy", {31'd0, o_Busy}, 0);
    chk("mid_rst_ovf",  {31'd0, o_Overflow}, 0);
    chk("mid_rst_seq",  {24'd0, o_Seq}, 0);
    keep = got_q.size();
    repeat (30) tick();
    chk("mid_no_dv", got_q.size(), keep);
    got_q.delete(); exp_q.delete(); mq.delete();
    mseq = 8'h00; mocc = 0; movf = 1'b0;
    for (int i = 0; i < 4; i++) push(8'($urandom), 0);
    compare_stream("post_rst");
    chk("post_rst_seq", {24'd0, o_Seq}, 1);

    // Push into a full FIFO in the same cycle as the DATA[0] pop
    uart_hold = 1'b1;
    for (int i = 0; i < 8; i++) push(8'($urandom), 0);
    tick();
    chk("full_no_ovf", {31'd0, o_Overflow}, 0);
    base = done_cnt;
    uart_hold = 1'b0;
    for (int i = 0; i < 2000 && done_cnt < base + 2; i++) tick();
    chk("full_dones", done_cnt, base + 2);
    tick();
    push(8'($urandom), 1);
    chk("popfull_ovf", {31'd0, o_Overflow}, 0);
    for (int i = 0; i < 3; i++) push(8'($urandom), 0);
    compare_stream("popfull");
    chk("popfull_ovf_end", {31'd0, o_Overflow}, {31'd0, movf});
    chk("popfull_seq", {24'd0, o_Seq}, {24'd0, mseq});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
